demo_txn_sequencer: RTL and testbench
=====================================

Name: demo_txn_sequencer

Overview:
- Parametrised transaction sequencer for the bus demo top. Replaces the fixed two-master start/edge logic with an N-channel generator.
- Debounces the start button and turns each press into per-channel bus requests: single-step or burst.
- Each request draws from a per-channel address table and drives a ready/valid request port toward one bus master.
- Latches response data for a selectable display output and counts completed transactions.

Parameters:
NUM_CH, 2, number of master channels (1..8)
ADDR_WIDTH, 16, request address width
DATA_WIDTH, 8, data width (>= 8)
DEPTH, 4, address-table entries per channel (power of 2, >= 2)
DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a start_n level change
ADDR_TABLE, {16'h0009,16'h2005,16'h0005,16'h0001,16'h1004,16'h1004,16'h0003,16'h0002}, entry k of channel c at bits [(c*DEPTH+k)*ADDR_WIDTH +: ADDR_WIDTH]
CH_W (localparam), max(1,$clog2(NUM_CH)), channel select width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start_n  in  1  raw push button, active-low, asynchronous to clk
burst  in  1  0: one transaction per press; 1: DEPTH transactions per press
ch_enable  in  NUM_CH  per-channel participation, sampled on press event
ch_mode  in  NUM_CH  per-channel 0=read, 1=write, sampled on entry to ISSUE
req_valid  out  NUM_CH  request valid to master c
req_ready  in  NUM_CH  master c accepts request
req_addr  out  NUM_CH*ADDR_WIDTH  request address
req_wdata  out  NUM_CH*DATA_WIDTH  write data
req_mode  out  NUM_CH  latched mode
rsp_valid  in  NUM_CH  one-cycle completion pulse from master c
rsp_rdata  in  NUM_CH*DATA_WIDTH  read data, valid with rsp_valid
disp_sel  in  CH_W  display channel select
disp_data  out  DATA_WIDTH  last data of selected channel
busy  out  1  OR of all channels not IDLE
txn_count  out  16  completed transactions, saturating

Behaviour:
- Reset: all state flops clear in the cycle rstn=0. req_valid=0, req_addr=0, req_wdata=0, req_mode=0, idx=0, wr_cnt=0, last_data=0, txn_count=0, busy=0. Debounced level and sync flops reset to 1. Reset mid-transaction abandons it with no completion.
- Debounce: start_n passes a 2-flop synchroniser. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples that differ from it. press_evt is a one-cycle pulse on a debounced 1->0 transition.
- Per-channel FSM, states IDLE, ISSUE, WAIT:
  - IDLE -> ISSUE on press_evt & ch_enable[c]. A press while not IDLE is ignored for that channel; no queueing.
  - ISSUE: req_valid=1 from the cycle after press_evt. req_addr = table[c][idx]; req_mode latched on entry; req_wdata = (c<<4)|wr_cnt[3:0], zero-extended. Outputs are held stable until req_valid & req_ready, then go to WAIT with req_valid=0 the next cycle.
  - WAIT: on rsp_valid, last_data[c] = rsp_rdata (read) or req_wdata (write). idx = idx+1 mod DEPTH. wr_cnt increments on writes. txn_count increments.
  - Next state after completion: ISSUE if burst latched at press =1 and this completion was not the DEPTH-th of the burst; else IDLE.
- rsp_valid in IDLE or ISSUE is ignored.
- Simultaneous completions on k channels in one cycle add k to txn_count, which saturates at 16'hFFFF.
- ch_enable deasserted mid-burst does not stop the burst; enable is checked only at press.
- idx persists across presses and wraps DEPTH-1 -> 0.
- disp_data is combinational from last_data[disp_sel]. disp_sel >= NUM_CH gives 0.

Decomposition:
- Package demo_pkg: ch_state_t enum {IDLE, ISSUE, WAIT}, MODE_READ=0 / MODE_WRITE=1 constants, table-index helper function.
- Sub-module demo_debounce (sync + stability counter + falling-edge pulse), parameter DEBOUNCE_CYCLES.
- Per-channel FSM in a generate loop.

Test Plan:
- Single read, ch0 only, burst=0: press, hold req_ready=1, rsp_rdata=0x5A -> one request with addr 0x0002, mode 0; disp_sel=0 shows 0x5A; txn_count=1; busy falls after rsp.
- Burst write, ch1 only, burst=1: one press -> addrs 0x0001, 0x0005, 0x2005, 0x0009 with wdata 0x10, 0x11, 0x12, 0x13; txn_count=4; idx wraps to 0.
- Glitch shorter than DEBOUNCE_CYCLES (low for 3 cycles) -> no press_evt and no req_valid. A 20-cycle press -> exactly one press_evt.
- Wrap: five single presses on ch0 -> addrs 0x0002, 0x0003, 0x1004, 0x1004, 0x0002.
- Backpressure: req_ready=0 for 10 cycles -> req_valid, addr and mode held stable. A second press during this time is ignored, giving exactly one transaction.
- Both channels with simultaneous rsp_valid -> txn_count +2 in one cycle. Reset asserted in WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/demo_txn_sequencer_pkg.sv
// Shared types and helpers for the transaction sequencer: channel FSM
// states, request mode encodings and address-table indexing.
package demo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ch_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Flat entry number of entry `entry` of channel `ch` in the packed address table
    function automatic int tbl_idx(input int ch, input int entry, input int depth);
        return ch * depth + entry;
    endfunction

endpackage

// File: rtl/demo_txn_sequencer_if.sv
// Request/response bus between the sequencer and its bus masters.
// One ready/valid request lane and one completion lane per channel.
interface demo_txn_sequencer_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CH-1:0]            req_mode;
    logic [NUM_CH-1:0]            rsp_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] rsp_rdata;

    // Sequencer side: issues requests, receives completions
    modport master (
        output req_valid, req_addr, req_wdata, req_mode,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Bus-master side: accepts requests, returns completions
    modport slave (
        input  req_valid, req_addr, req_wdata, req_mode,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/demo_txn_sequencer_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press (debounced 1->0 transition).
module demo_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_start_n,
    output logic o_press_evt
);
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_sync;

    // Bring the asynchronous button into the clock domain (idles high)
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values
        if (!rstn) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_start_n};
    end

    assign w_sync = r_sync[1];

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_sync != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= w_sync;
                    r_cnt   <= '0;
                    r_press <= ~w_sync;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press_evt = r_press;

endmodule

// File: rtl/demo_txn_sequencer.sv
// N-channel transaction sequencer: each debounced button press launches a
// single request or a DEPTH-long burst on every enabled channel, walking a
// per-channel address table. Completions update a display latch and a
// saturating transaction counter.
module demo_txn_sequencer
    import demo_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter logic [NUM_CH*DEPTH*ADDR_WIDTH-1:0] ADDR_TABLE =
        {16'h0009, 16'h2005, 16'h0005, 16'h0001, 16'h1004, 16'h1004, 16'h0003, 16'h0002},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_n,
    input  logic                   burst,
    input  logic [NUM_CH-1:0]      ch_enable,
    input  logic [NUM_CH-1:0]      ch_mode,
    demo_txn_sequencer_if.master   bus,
    input  logic [CH_W-1:0]        disp_sel,
    output logic [DATA_WIDTH-1:0]  disp_data,
    output logic                   busy,
    output logic [15:0]            txn_count
);
    localparam int IW = $clog2(DEPTH);

    logic                         w_press_evt;
    logic [NUM_CH-1:0]            w_valid;
    logic [NUM_CH-1:0]            w_mode;
    logic [NUM_CH-1:0]            w_done;
    logic [NUM_CH-1:0]            w_busy;
    logic [NUM_CH*ADDR_WIDTH-1:0] w_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] w_wdata;
    logic [NUM_CH*DATA_WIDTH-1:0] w_last;
    logic [3:0]                   w_done_cnt;
    logic [16:0]                  w_txn_sum;
    logic [15:0]                  r_txn;

    demo_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rstn       (rstn),
        .i_start_n  (start_n),
        .o_press_evt(w_press_evt)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [3:0] CH_ID = 4'(c);

        ch_state_t             r_state;
        logic                  r_valid;
        logic                  r_mode;
        logic                  r_burst;
        logic [ADDR_WIDTH-1:0] r_addr;
        logic [DATA_WIDTH-1:0] r_wdata;
        logic [DATA_WIDTH-1:0] r_last;
        logic [IW-1:0]         r_idx;
        logic [IW-1:0]         r_beat;
        logic [3:0]            r_wr_cnt;

        logic [IW-1:0]         w_idx_next;
        logic [3:0]            w_wr_next;
        logic [ADDR_WIDTH-1:0] w_addr_cur;
        logic [ADDR_WIDTH-1:0] w_addr_next;
        logic [DATA_WIDTH-1:0] w_wdata_cur;
        logic [DATA_WIDTH-1:0] w_wdata_next;
        logic [DATA_WIDTH-1:0] w_rdata;

        // DEPTH is a power of two, so the index wraps on its own
        assign w_idx_next   = r_idx + 1'b1;
        assign w_wr_next    = (r_mode == MODE_WRITE) ? r_wr_cnt + 4'd1 : r_wr_cnt;
        assign w_addr_cur   = ADDR_TABLE[tbl_idx(c, int'(r_idx), DEPTH)*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_addr_next  = ADDR_TABLE[tbl_idx(c, int'(w_idx_next), DEPTH)*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_cur  = DATA_WIDTH'({CH_ID, r_wr_cnt});
        assign w_wdata_next = DATA_WIDTH'({CH_ID, w_wr_next});
        assign w_rdata      = bus.rsp_rdata[c*DATA_WIDTH +: DATA_WIDTH];

        // Channel FSM: launch on press, hold request until accepted, wait for completion
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_state  <= IDLE;
                r_valid  <= 1'b0;
                r_mode   <= MODE_READ;
                r_burst  <= 1'b0;
                r_addr   <= '0;
                r_wdata  <= '0;
                r_last   <= '0;
                r_idx    <= '0;
                r_beat   <= '0;
                r_wr_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press_evt && ch_enable[c]) begin
                            r_state <= ISSUE;
                            r_valid <= 1'b1;
                            r_addr  <= w_addr_cur;
                            r_wdata <= w_wdata_cur;
                            r_mode  <= ch_mode[c];
                            r_burst <= burst;
                            r_beat  <= '0;
                        end
                    end
                    ISSUE: begin
                        if (bus.req_ready[c]) begin
                            r_state <= WAIT;
                            r_valid <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (bus.rsp_valid[c]) begin
                            r_last   <= (r_mode == MODE_WRITE) ? r_wdata : w_rdata;
                            r_idx    <= w_idx_next;
                            r_wr_cnt <= w_wr_next;
                            if (r_burst && (r_beat != IW'(DEPTH - 1))) begin
                                r_state <= ISSUE;
                                r_valid <= 1'b1;
                                r_addr  <= w_addr_next;
                                r_wdata <= w_wdata_next;
                                r_mode  <= ch_mode[c];
                                r_beat  <= r_beat + 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end

        assign w_valid[c]                             = r_valid;
        assign w_mode[c]                              = r_mode;
        assign w_addr[c*ADDR_WIDTH +: ADDR_WIDTH]     = r_addr;
        assign w_wdata[c*DATA_WIDTH +: DATA_WIDTH]    = r_wdata;
        assign w_last[c*DATA_WIDTH +: DATA_WIDTH]     = r_last;
        assign w_done[c]                              = (r_state == WAIT) && bus.rsp_valid[c];
        assign w_busy[c]                              = (r_state != IDLE);
    end

    assign bus.req_valid = w_valid;
    assign bus.req_mode  = w_mode;
    assign bus.req_addr  = w_addr;
    assign bus.req_wdata = w_wdata;
    assign busy          = |w_busy;

    // Number of channels completing in this cycle
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the value held (no latch)
        w_done_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_done_cnt = w_done_cnt + {3'b000, w_done[c]};
        end
    end

    assign w_txn_sum = {1'b0, r_txn} + {13'd0, w_done_cnt};

    // Saturating count of completed transactions
    always_ff @(posedge clk) begin
        if (!rstn)             r_txn <= '0;
        else if (w_txn_sum[16]) r_txn <= 16'hFFFF;
        else                   r_txn <= w_txn_sum[15:0];
    end

    assign txn_count = r_txn;

    // Display mux; selects beyond the channel count read as zero
    always_comb begin
        disp_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (disp_sel == CH_W'(c)) disp_data = w_last[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_demo_txn_sequencer.sv
// Self-checking bench for demo_txn_sequencer. A behavioural bus-master model
// accepts requests with random backpressure and latency, predicts each
// request from the address table and per-channel counters, and tracks the
// expected display data and transaction count.
module tb_demo_txn_sequencer;
    localparam int NUM_CH     = 2;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 4;
    localparam int DEB        = 4;
    localparam int CH_W       = 1;
    localparam int IDLE_LIMIT = 2000;

    logic                  clk       = 1'b0;
    logic                  rstn      = 1'b0;
    logic                  start_n   = 1'b1;
    logic                  burst     = 1'b0;
    logic [NUM_CH-1:0]     ch_enable = '0;
    logic [NUM_CH-1:0]     ch_mode   = '0;
    logic [CH_W-1:0]       disp_sel  = '0;
    logic [DATA_WIDTH-1:0] disp_data;
    logic                  busy;
    logic [15:0]           txn_count;

    demo_txn_sequencer_if #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    demo_txn_sequencer #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start_n  (start_n),
        .burst    (burst),
        .ch_enable(ch_enable),
        .ch_mode  (ch_mode),
        .bus      (bus),
        .disp_sel (disp_sel),
        .disp_data(disp_data),
        .busy     (busy),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Address table as listed for each channel, entry 0 first
    logic [15:0] tbl [NUM_CH][DEPTH] = '{'{16'h0002, 16'h0003, 16'h1004, 16'h1004},
                                         '{16'h0001, 16'h0005, 16'h2005, 16'h0009}};

    int          idx_m   [NUM_CH];
    int          wr_m    [NUM_CH];
    int          beats_m [NUM_CH];
    int          wait_m  [NUM_CH];
    int          stall_m [NUM_CH];
    int          lat_cfg [NUM_CH];
    bit          mode_m  [NUM_CH];
    bit          in_flight[NUM_CH];
    bit          accepting[NUM_CH];
    logic [7:0]  last_m  [NUM_CH];
    int          txn_m;
    bit          rand_ready;
    bit          rand_lat;
    bit          seen_double;
    logic [15:0] prev_txn;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] exp_wdata(input int c);
        return 8'(c * 16 + (wr_m[c] % 16));
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            idx_m[c] = 0;  wr_m[c] = 0;  beats_m[c] = 0;  wait_m[c] = 0;
            stall_m[c] = 0;  mode_m[c] = 1'b0;  in_flight[c] = 1'b0;
            accepting[c] = 1'b0;  last_m[c] = 8'h00;
        end
        txn_m = 0;
    endfunction

    // A press starts work only on enabled channels that have nothing outstanding
    function automatic void model_press();
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_enable[c] && beats_m[c] == 0) begin
                beats_m[c] = burst ? DEPTH : 1;
                mode_m[c]  = ch_mode[c];
            end
        end
    endfunction

    function automatic bit model_idle();
        for (int c = 0; c < NUM_CH; c++) begin
            if (beats_m[c] != 0 || in_flight[c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One negedge of the bus-master model for channel c
    task automatic resp_step(input int c);
        logic [7:0] rd;
        bus.rsp_valid[c] = 1'b0;
        if (!rstn) begin
            bus.req_ready[c] = 1'b0;
            accepting[c] = 1'b0;
            in_flight[c] = 1'b0;
            return;
        end
        if (accepting[c]) begin
            accepting[c] = 1'b0;
            check($sformatf("valid_drop_ch%0d", c), 32'(bus.req_valid[c]), 32'd0);
            in_flight[c] = 1'b1;
            wait_m[c] = rand_lat ? int'($urandom_range(0, 4)) : lat_cfg[c];
        end
        if (in_flight[c]) begin
            bus.req_ready[c] = 1'b0;
            if (wait_m[c] == 0) begin
                rd = 8'($urandom);
                bus.rsp_valid[c] = 1'b1;
                bus.rsp_rdata[c*DATA_WIDTH +: DATA_WIDTH] = rd;
                last_m[c] = mode_m[c] ? exp_wdata(c) : rd;
                if (mode_m[c]) wr_m[c]++;
                idx_m[c] = (idx_m[c] + 1) % DEPTH;
                beats_m[c]--;
                if (txn_m < 16'hFFFF) txn_m++;
                in_flight[c] = 1'b0;
            end else begin
                wait_m[c]--;
            end
        end else if (beats_m[c] == 0) begin
            bus.req_ready[c] = 1'b0;
            check($sformatf("spurious_req_ch%0d", c), 32'(bus.req_valid[c]), 32'd0);
        end else if (bus.req_valid[c]) begin
            check($sformatf("req_addr_ch%0d", c),
                  32'(bus.req_addr[c*ADDR_WIDTH +: ADDR_WIDTH]), 32'(tbl[c][idx_m[c]]));
            check($sformatf("req_mode_ch%0d", c), 32'(bus.req_mode[c]), 32'(mode_m[c]));
            check($sformatf("req_wdata_ch%0d", c),
                  32'(bus.req_wdata[c*DATA_WIDTH +: DATA_WIDTH]), 32'(exp_wdata(c)));
            if (stall_m[c] > 0) begin
                stall_m[c]--;
                bus.req_ready[c] = 1'b0;
            end else if (rand_ready && $urandom_range(0, 2) == 0) begin
                bus.req_ready[c] = 1'b0;
            end else begin
                bus.req_ready[c] = 1'b1;
                accepting[c] = 1'b1;
            end
        end else begin
            bus.req_ready[c] = 1'b0;
        end
    endtask

    // Bus-master model for all channels, plus a watch for double completions
    initial begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        prev_txn = '0;
        forever begin
            @(negedge clk);
            if (rstn && txn_count == prev_txn + 16'd2) seen_double = 1'b1;
            prev_txn = txn_count;
            for (int c = 0; c < NUM_CH; c++) resp_step(c);
        end
    end

    task automatic press(input int low, input int high, input bit real_press);
        if (real_press) model_press();
        start_n = 1'b0;
        repeat (low) step();
        start_n = 1'b1;
        repeat (high) step();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(model_idle() && busy == 1'b0) && n < IDLE_LIMIT) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(n < IDLE_LIMIT), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_txn"}, 32'(txn_count), 32'(txn_m));
    endtask

    task automatic check_disp(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            disp_sel = CH_W'(c);
            #1;
            check($sformatf("%s_disp%0d", tag, c), 32'(disp_data), 32'(last_m[c]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.req_valid), 32'd0);
        check({tag, "_addr"},  32'(bus.req_addr),  32'd0);
        check({tag, "_wdata"}, 32'(bus.req_wdata), 32'd0);
        check({tag, "_mode"},  32'(bus.req_mode),  32'd0);
        check({tag, "_busy"},  32'(busy),          32'd0);
        check({tag, "_txn"},   32'(txn_count),     32'd0);
        check_disp(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0;
        bad = 0;
        seen_double = 1'b0;
        rand_ready = 1'b0;
        rand_lat = 1'b0;
        model_reset();
        for (int c = 0; c < NUM_CH; c++) lat_cfg[c] = 1;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (5) step();

        // Single read on channel 0
        ch_enable = 2'b01;  ch_mode = 2'b00;  burst = 1'b0;  lat_cfg[0] = 3;
        press(20, 20, 1'b1);
        wait_idle("single_read");
        check_disp("single_read");

        // A 3-cycle glitch must not launch anything
        press(3, 20, 1'b0);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_txn", 32'(txn_count), 32'(txn_m));

        // Burst of writes on channel 1
        ch_enable = 2'b10;  ch_mode = 2'b10;  burst = 1'b1;
        press(20, 20, 1'b1);
        wait_idle("burst_write");
        check_disp("burst_write");

        // Repeated single reads on channel 0 walk and wrap the table
        ch_enable = 2'b01;  ch_mode = 2'b00;  burst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            press(20, 20, 1'b1);
            wait_idle($sformatf("wrap%0d", i));
        end
        check_disp("wrap");

        // Backpressure, with a second press while the request is stalled
        n = txn_m;
        stall_m[0] = 40;
        press(8, 8, 1'b1);
        press(8, 8, 1'b1);
        wait_idle("backpressure");
        check("bp_one_txn", 32'(txn_count), 32'(n + 1));

        // Both channels complete in the same cycle
        ch_enable = 2'b11;  ch_mode = 2'b10;  burst = 1'b0;
        lat_cfg[0] = 2;  lat_cfg[1] = 2;
        seen_double = 1'b0;
        press(20, 20, 1'b1);
        wait_idle("dual");
        check("dual_completion", 32'(seen_double), 32'd1);
        check_disp("dual");

        // Randomised enables, modes, burst and bus timing
        rand_ready = 1'b1;
        rand_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ch_enable = 2'($urandom_range(1, 3));
            ch_mode   = 2'($urandom);
            burst     = 1'($urandom);
            press(20, 20, 1'b1);
            wait_idle($sformatf("rand%0d", i));
            check_disp($sformatf("rand%0d", i));
        end
        rand_ready = 1'b0;
        rand_lat = 1'b0;

        // Reset while channel 0 waits for its response
        ch_enable = 2'b01;  ch_mode = 2'b00;  burst = 1'b0;  lat_cfg[0] = 15;
        model_press();
        start_n = 1'b0;
        n = 0;
        while (!in_flight[0] && n < 200) begin
            step();
            n++;
        end
        check("reach_wait", 32'(in_flight[0]), 32'd1);
        rstn = 1'b0;
        start_n = 1'b1;
        model_reset();
        step();
        check_reset_outputs("mid_reset");
        rstn = 1'b1;
        repeat (10) step();
        check("post_reset_busy", 32'(busy), 32'd0);
        lat_cfg[0] = 1;
        press(20, 20, 1'b1);
        wait_idle("post_reset");
        check_disp("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
